// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   NREQ_DEFAULT : default number of requesters sharing one transmitter
//   DW_DEFAULT   : default byte width (matches the transmitter data width)
//   arb_state_e  : arbiter FSM state encoding
package uart_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int DW_DEFAULT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority search.
// The search starts one position after last_owner and wraps, so the most
// recent grantee has the lowest priority.
//   req        in  NREQ  request vector
//   last_owner in  IW    index of the previous grantee
//   grant      out IW    index of the winning requester (0 when none)
//   found      out 1     at least one request bit was set
module rr_pick
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IW   = $clog2(NREQ_DEFAULT)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [IW-1:0]   grant,
    output logic            found
);

    // Walk offsets from farthest to nearest so that the nearest valid
    // requester (highest priority) is the last one written.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_owner) + k) % NREQ;
            if (req[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte sources.
// Grants rotate round-robin per message; a message that spans several bytes
// keeps the grant (locked) until its byte flagged req_last has been sent.
//   clk         in   1        system clock, rising edge
//   rst         in   1        synchronous active-high reset
//   req_valid   in   NREQ     per-requester byte available
//   req_data    in   NREQ*DW  per-requester byte, requester i at [i*DW +: DW]
//   req_last    in   NREQ     byte is the final one of its message
//   req_ready   out  NREQ     one-hot acceptance pulse (IDLE only)
//   tran_start  out  1        start request to the transmitter
//   trans_data  out  DW       byte presented to the transmitter
//   tx_busy     in   1        transmitter busy
//   owner       out  OW       current / most recent grantee
//   locked      out  1        a multi-byte message holds the grant
//
// state        | meaning
// ST_IDLE      | arbitrate; accept one byte and latch it
// ST_LOAD      | tran_start raised with the latched byte
// ST_WAIT_BUSY | hold tran_start until the transmitter reports busy
// ST_WAIT_DONE | wait for the transmitter to finish, then update the lock
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int DW   = DW_DEFAULT,
    localparam int OW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               tran_start,
    output logic [DW-1:0]      trans_data,
    input  logic               tx_busy,
    output logic [OW-1:0]      owner,
    output logic               locked
);

    arb_state_e         state_q;
    logic [OW-1:0]      owner_q;
    logic               locked_q;
    logic               last_q;
    logic [DW-1:0]      data_q;
    logic               tran_start_q;

    logic [NREQ-1:0]    owner_mask;
    logic [NREQ-1:0]    cand;
    logic [OW-1:0]      pick_idx;
    logic               pick_found;
    logic               grant_en;
    logic [DW-1:0]      sel_data;

    // While locked only the owner may be served; the rr search still works
    // because the owner sits at the last position of its own search order.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        cand                = locked_q ? (req_valid & owner_mask) : req_valid;
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_rr_pick (
        .req        (cand),
        .last_owner (owner_q),
        .grant      (pick_idx),
        .found      (pick_found)
    );

    assign sel_data = req_data[int'(pick_idx)*DW +: DW];

    // The acceptance pulse has to coincide with the IDLE cycle that latches
    // the byte, so it is decoded from the current state rather than registered.
    assign grant_en = (state_q == ST_IDLE) && pick_found && !rst;

    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OW'(NREQ - 1);
            locked_q     <= 1'b0;
            last_q       <= 1'b0;
            data_q       <= '0;
            tran_start_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        owner_q      <= pick_idx;
                        data_q       <= sel_data;
                        last_q       <= req_last[pick_idx];
                        tran_start_q <= 1'b1;
                        state_q      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        tran_start_q <= 1'b0;
                        state_q      <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        locked_q <= !last_q;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tran_start = tran_start_q;
    assign trans_data = data_q;
    assign owner      = owner_q;
    assign locked     = locked_q;

endmodule
